// File: rtl/wrr_credit_masker.sv
// Weighted round-robin credit masker placed in front of a plain round-robin arbiter.
// Each client spends one credit per acknowledged grant. Once every pending
// requester is out of credit, all credits are reloaded from the weights in a
// one-cycle RELOAD bubble.
module wrr_credit_masker #(
  parameter int N   = 32,
  parameter int IDW = 5,
  parameter int WW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    raw_req,
  input  logic [N*WW-1:0] weight_cfg,
  input  logic            cfg_load,
  input  logic [N-1:0]    gnt_w,
  input  logic [IDW-1:0]  gnt_id,
  input  logic            ack,
  output logic [N-1:0]    req,
  output logic            round_done,
  output logic [15:0]     round_cnt,
  output logic            grant_err
);

  typedef enum logic {RUN = 1'b0, RELOAD = 1'b1} state_t;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [WW-1:0] weight_q [N];
  logic [WW-1:0] weight_d [N];
  logic [WW-1:0] credit_q [N];
  logic [WW-1:0] credit_d [N];
  logic [15:0]   cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [N-1:0]  wt_nz, elig, pending, elig_post;
  logic [N-1:0]  gnt_exp;
  logic          gnt_bad;
  logic          spend;

  // Per-client eligibility from the registered weights and credits
  always_comb begin
    wt_nz = '0;
    elig  = '0;
    for (int i = 0; i < N; i++) begin
      wt_nz[i] = (weight_q[i] != '0);
      elig[i]  = raw_req[i] & wt_nz[i] & (credit_q[i] != '0);
    end
    pending = raw_req & wt_nz;
  end

  // Grant sanity: the one-hot vector must equal the decoded index (this also rejects zero and multi-hot vectors)
  always_comb begin
    gnt_exp = ONE_HOT0 << gnt_id;
    gnt_bad = ack && (gnt_w != gnt_exp);
  end

  // Next-state: credit spend, reload decision, weight latch, round counting
  always_comb begin
    state_d   = state_q;
    weight_d  = weight_q;
    credit_d  = credit_q;
    cnt_d     = cnt_q;
    err_d     = err_q | gnt_bad;
    spend     = 1'b0;
    elig_post = '0;

    if (cfg_load) begin
      // New weights take effect immediately and become the fresh credits
      for (int i = 0; i < N; i++) begin
        weight_d[i] = weight_cfg[i*WW +: WW];
        credit_d[i] = weight_cfg[i*WW +: WW];
      end
      state_d = RELOAD;
      cnt_d   = cnt_q + 16'd1;
    end else if (state_q == RELOAD) begin
      state_d = RUN;
    end else begin
      spend = ack && (gnt_w != '0) && !gnt_bad;
      // A late grant to an exhausted client leaves its credit at zero
      if (spend && (credit_q[gnt_id] != '0))
        credit_d[gnt_id] = credit_q[gnt_id] - WW'(1);
      // Reload decision looks at credits after this cycle's spend
      for (int i = 0; i < N; i++)
        elig_post[i] = pending[i] & (credit_d[i] != '0);
      if ((elig_post == '0) && (pending != '0)) begin
        for (int i = 0; i < N; i++)
          credit_d[i] = weight_q[i];
        state_d = RELOAD;
        cnt_d   = cnt_q + 16'd1;
      end
    end
  end

  // State, weight and credit registers; reset restores plain round-robin
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= WW'(1);
        credit_q[i] <= WW'(1);
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      weight_q <= weight_d;
      credit_q <= credit_d;
    end
  end

  // Outputs: req is a combinational mask, forced low during reset and the RELOAD bubble
  always_comb begin
    req        = (rst && (state_q == RUN)) ? elig : '0;
    round_done = (state_q == RELOAD);
    round_cnt  = cnt_q;
    grant_err  = err_q;
  end

endmodule

// File: tb/tb_wrr_credit_masker.sv
// Self-checking bench for wrr_credit_masker: directed scenarios plus randomized
// traffic, all checked against a behavioural credit/round model.
module tb_wrr_credit_masker;
  localparam int N   = 32;
  localparam int IDW = 5;
  localparam int WW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    raw_req;
  logic [N*WW-1:0] weight_cfg;
  logic            cfg_load;
  logic [N-1:0]    gnt_w;
  logic [IDW-1:0]  gnt_id;
  logic            ack;
  logic [N-1:0]    req;
  logic            round_done;
  logic [15:0]     round_cnt;
  logic            grant_err;

  wrr_credit_masker #(.N(N), .IDW(IDW), .WW(WW)) dut (
    .clk(clk), .rst(rst), .raw_req(raw_req), .weight_cfg(weight_cfg),
    .cfg_load(cfg_load), .gnt_w(gnt_w), .gnt_id(gnt_id), .ack(ack),
    .req(req), .round_done(round_done), .round_cnt(round_cnt), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  int m_w [N];
  int m_c [N];
  bit m_rl;
  int m_cnt;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_w[i] = 1; m_c[i] = 1; end
    m_rl = 0; m_cnt = 0; m_err = 0;
  endtask

  function automatic logic [N-1:0] m_req(input logic [N-1:0] r);
    logic [N-1:0] v = '0;
    if (!m_rl)
      for (int i = 0; i < N; i++)
        v[i] = r[i] && (m_w[i] != 0) && (m_c[i] != 0);
    return v;
  endfunction

  task automatic m_update(input logic [N-1:0] r, input logic cl, input logic [N*WW-1:0] wc,
                          input logic a, input logic [N-1:0] gw, input logic [IDW-1:0] gi);
    bit bd, pend, el;
    bd = a && (($countones(gw) != 1) || (gw[gi] !== 1'b1));
    if (bd) m_err = 1;
    if (cl) begin
      for (int i = 0; i < N; i++) begin m_w[i] = int'(wc[i*WW +: WW]); m_c[i] = m_w[i]; end
      m_rl = 1; m_cnt = (m_cnt + 1) % 65536;
    end else if (m_rl) begin
      m_rl = 0;
    end else begin
      if (a && (gw != 0) && !bd && (m_c[int'(gi)] > 0)) m_c[int'(gi)]--;
      pend = 0; el = 0;
      for (int i = 0; i < N; i++)
        if (r[i] && (m_w[i] != 0)) begin pend = 1; if (m_c[i] != 0) el = 1; end
      if (pend && !el) begin
        for (int i = 0; i < N; i++) m_c[i] = m_w[i];
        m_rl = 1; m_cnt = (m_cnt + 1) % 65536;
      end
    end
  endtask

  // One clock cycle: drive, check req before the edge, update model, check registered outputs after
  task automatic step(input logic [N-1:0] r, input logic cl, input logic [N*WW-1:0] wc,
                      input logic a, input logic [N-1:0] gw, input logic [IDW-1:0] gi);
    raw_req = r; cfg_load = cl; weight_cfg = wc; ack = a; gnt_w = gw; gnt_id = gi;
    #2;
    chk("req", req, m_req(r));
    @(posedge clk);
    m_update(r, cl, wc, a, gw, gi);
    #1;
    chk("round_done", 32'(round_done), 32'(m_rl));
    chk("round_cnt", 32'(round_cnt), 32'(m_cnt));
    chk("grant_err", 32'(grant_err), 32'(m_err));
  endtask

  // Bench arbiter: lowest-index winner of the model's expected req, always acked
  task automatic arb_step(input logic [N-1:0] r);
    logic [N-1:0] mr;
    int id;
    mr = m_req(r);
    id = -1;
    for (int i = N - 1; i >= 0; i--) if (mr[i]) id = i;
    if (id >= 0) step(r, 1'b0, '0, 1'b1, N'(1) << id, IDW'(id));
    else         step(r, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Asynchronous reset pulse away from the clock edge, checked immediately
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_req", req, '0);
    chk("rst_cnt", 32'(round_cnt), 32'd0);
    chk("rst_err", 32'(grant_err), 32'd0);
    chk("rst_done", 32'(round_done), 32'd0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  function automatic logic [N*WW-1:0] wset(input int a_id, input int a_w, input int b_id, input int b_w, input int dflt);
    logic [N*WW-1:0] v;
    for (int i = 0; i < N; i++) v[i*WW +: WW] = WW'(dflt);
    v[a_id*WW +: WW] = WW'(a_w);
    v[b_id*WW +: WW] = WW'(b_w);
    return v;
  endfunction

  initial begin
    logic [N-1:0]    r;
    logic [N*WW-1:0] wc;
    int              id;

    rst = 1'b0; raw_req = 32'h3; weight_cfg = '0; cfg_load = 0; gnt_w = '0; gnt_id = '0; ack = 0;
    m_reset();
    #1;
    chk("init_req", req, '0);
    chk("init_cnt", 32'(round_cnt), 32'd0);
    chk("init_err", 32'(grant_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    step(32'h3, 0, '0, 0, '0, '0);
    chk("post_rst_req3", req, 32'h3);

    // Weighting: client0=3, client1=1 -> grants 0,0,0,1 then a bubble, every 5 cycles
    step(32'h3, 1, wset(0, 3, 1, 1, 0), 0, '0, '0);
    for (int k = 0; k < 15; k++) arb_step(32'h3);

    // Reset mid-traffic
    arb_step(32'h3);
    do_reset();
    step(32'h3, 0, '0, 0, '0, '0);

    // Disabled client 5: no req, no reload
    step(32'h20, 1, wset(5, 0, 5, 0, 1), 0, '0, '0);
    step(32'h20, 0, '0, 0, '0, '0);
    for (int k = 0; k < 6; k++) arb_step(32'h20);
    chk("dis_req", req, '0);
    chk("dis_cnt", 32'(round_cnt), 32'd1);

    // cfg_load together with an ack: the spend is discarded, credit[2] becomes 4
    step(32'h4, 1, wset(2, 2, 2, 2, 0), 0, '0, '0);
    step(32'h4, 0, '0, 0, '0, '0);
    step(32'h4, 1, wset(2, 4, 2, 4, 0), 1, 32'h4, 5'd2);
    chk("cfgack_cnt", 32'(round_cnt), 32'd3);
    for (int k = 0; k < 6; k++) arb_step(32'h4);

    // Grant errors: multi-hot, then index mismatch
    do_reset();
    step(32'h6, 0, '0, 1, 32'h6, 5'd1);
    chk("err_multi", 32'(grant_err), 32'd1);
    for (int k = 0; k < 4; k++) arb_step(32'h6);
    chk("err_sticky", 32'(grant_err), 32'd1);
    do_reset();
    step(32'hC, 0, '0, 1, 32'h4, 5'd3);
    chk("err_idx", 32'(grant_err), 32'd1);
    do_reset();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom() & $urandom();
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < N; i++)
          wc[i*WW +: WW] = ($urandom_range(0, 3) == 0) ? '0 : WW'($urandom_range(1, 15));
        id = $urandom_range(0, N - 1);
        step(r, 1, wc, 1'($urandom_range(0, 1)), N'(1) << id, IDW'(id));
      end else if ($urandom_range(0, 60) == 0) begin
        step(r, 0, '0, 1, N'($urandom()), IDW'($urandom_range(0, N - 1)));
      end else if ($urandom_range(0, 3) != 0) begin
        arb_step(r);
      end else begin
        step(r, 0, '0, 0, '0, '0);
      end
      if (k == 200) do_reset();
    end

    // round_cnt wrap by holding cfg_load
    do_reset();
    wc = wset(0, 1, 0, 1, 1);
    for (int k = 0; k < 65535; k++) step(32'h1, 1, wc, 0, '0, '0);
    chk("cnt_ffff", 32'(round_cnt), 32'hFFFF);
    step(32'h1, 1, wc, 0, '0, '0);
    chk("cnt_wrap", 32'(round_cnt), 32'h0);
    step(32'h1, 0, '0, 0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wrr_credit_masker.md
Name: wrr_credit_masker

Overview:
- Upstream stage of the round-robin arbiter. Converts plain round-robin arbitration into weighted round-robin.
- Holds a per-client weight and a per-client credit counter, and masks raw client requests onto the arbiter's req bus.
- Consumes the arbiter's grant outputs (gnt_w, gnt_id) qualified by ack to spend credits.
- Reloads all credits when every pending requester has exhausted its credit.

Parameters:
- N, 32, number of clients (req/gnt_w width)
- IDW, 5, grant index width, equal to clog2(N)
- WW, 4, weight/credit width per client

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset; asynchronous, active-low
- raw_req  input  N  unmasked client requests
- weight_cfg  input  N*WW  packed weights; client i at bits [i*WW +: WW]
- cfg_load  input  1  latch weight_cfg and force a credit reload
- gnt_w  input  N  one-hot grant vector from the arbiter
- gnt_id  input  IDW  encoded grant index from the arbiter
- ack  input  1  grant consumed this cycle
- req  output  N  masked request to the arbiter
- round_done  output  1  one-cycle pulse when a credit reload occurs
- round_cnt  output  16  number of completed rounds; wraps
- grant_err  output  1  sticky flag for a grant encoding error

Behaviour:
- Reset (rst low, asynchronous):
  - weight[i]=1 and credit[i]=1 for all i.
  - State=RUN; round_cnt=0; round_done=0; grant_err=0.
  - req is forced to 0 while rst is low.
- Eligibility:
  - wt_nz[i] = (weight[i]!=0); a weight of 0 permanently disables the client.
  - elig[i] = raw_req[i] & wt_nz[i] & (credit[i]!=0).
- req = elig in state RUN; req = 0 in state RELOAD. req is combinational from registered state and raw_req, with no added latency.
- Spend: at a posedge in RUN with ack=1 and gnt_w!=0:
  - credit[gnt_id] decrements by 1, saturating at 0.
  - A late grant to a client whose credit is already 0 leaves the credit unchanged and raises no error.
- Grant check: when ack=1, grant_err is set if any of these holds:
  - gnt_w is not one-hot;
  - gnt_w != (1<<gnt_id);
  - gnt_w is 0.
  grant_err stays set until reset. Credits are not changed on an erroring ack.
- State machine (2 states):
  - RUN -> RELOAD when elig==0 and (raw_req & wt_nz)!=0, i.e. requesters are pending but all are out of credit. Evaluate this using credits after any decrement in the same cycle.
  - RUN -> RELOAD when cfg_load=1; weights are latched from weight_cfg at that edge.
  - RELOAD -> RUN unconditionally after 1 cycle.
  - On entry to RELOAD: credit[i] <= weight[i] using the new weights when cfg_load caused the entry; round_done pulses high for exactly the RELOAD cycle; round_cnt increments, wrapping 0xFFFF -> 0.
  - The RELOAD cycle is a one-cycle req bubble. An ack arriving during RELOAD is ignored for credit purposes but is still checked for grant_err.
- Idle: with raw_req & wt_nz == 0 there is no reload; credits hold.
- Simultaneous events:
  - cfg_load together with ack: cfg_load wins and the decrement is discarded.
  - cfg_load during RELOAD: weights are latched and credits reloaded again; state stays RELOAD one more cycle; round_done stays high and round_cnt increments again.
- All clients disabled (every weight 0): req stays 0 and no reloads occur.
- Reset mid-round: everything returns to reset values immediately; the first cycle after release behaves as plain RR (all weights 1).

Test Plan:
- Reset check: assert rst low mid-traffic -> req=0, round_cnt=0, grant_err=0 immediately; after release, raw_req=32'h3 gives req=32'h3.
- Weighting: weights client0=3, client1=1, others 0; cfg_load; raw_req=32'h3 held; the bench arbiter acks every grant -> grants follow the pattern 0,0,0,1 per round; round_done pulses every 5 cycles (4 acks + 1 bubble); req=0 in each RELOAD cycle.
- Disabled client: weight client5=0, raw_req=32'h20 -> req stays 0, no round_done, round_cnt unchanged.
- cfg_load with concurrent ack: credit[2]=2, ack on gnt_id=2 in the same cycle as cfg_load with weight 4 -> credit[2]=4 after reload, round_cnt+1.
- Grant error: ack with gnt_w=32'h6 -> grant_err=1 and stays set; credits unchanged. Separately, ack with gnt_w=32'h4 and gnt_id=3 -> grant_err=1.
- Wrap: preload via 65536 reloads (cfg_load pulses) -> round_cnt goes 0xFFFF -> 0x0000.
